// File: rtl/scaler_pkg.sv
// rtl/scaler_pkg.sv - shared FSM state type and constants for the scaler line writer
package scaler_pkg;

    // Buffers kept free so the line currently being read is never overwritten
    localparam int FIFO_GUARD = 1;

    // Default yScale fixed-point split (unsigned, integer.fraction)
    localparam int YS_INT_BITS  = 4;
    localparam int YS_FRAC_BITS = 14;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LINE = 3'd2,
        ST_SKIP = 3'd3,
        ST_ADV  = 3'd4,
        ST_STEP = 3'd5,
        ST_DONE = 3'd6
    } state_e;

endpackage

// File: rtl/scaler_line_select.sv
// rtl/scaler_line_select.sv - vertical line selection accumulator (active with LINE_SKIP_EN)
module scaler_line_select
    import scaler_pkg::*;
#(
    parameter int LINE_WIDTH      = 11,
    parameter int SCALE_INT_BITS  = YS_INT_BITS,
    parameter int SCALE_FRAC_BITS = YS_FRAC_BITS
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    clear_i,
    input  logic                                    step_i,
    input  logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0] y_scale_i,
    input  logic [LINE_WIDTH-1:0]                   line_i,
    output logic                                    needed_o,
    output logic                                    step_done_o
);

`ifdef LINE_SKIP_EN
    localparam int ACC_WIDTH = LINE_WIDTH + SCALE_FRAC_BITS;

    logic [ACC_WIDTH-1:0]  y_acc_q;
    logic [ACC_WIDTH-1:0]  y_acc_d;
    logic [LINE_WIDTH-1:0] y_need;

    assign y_need = y_acc_q[ACC_WIDTH-1:SCALE_FRAC_BITS];

    // A line is dropped only once the accumulator has moved past it; the
    // stepping rule keeps yNeed >= L-1, so "not beyond L" means L-1 or L.
    assign needed_o    = !(y_need > line_i);
    // A zero scale would never advance, so it is treated as already done.
    assign step_done_o = (y_scale_i == '0) || !(y_need < line_i);

    // Next accumulator value: clear at frame start, one add per requested step
    always_comb begin
        y_acc_d = y_acc_q;
        if (clear_i) begin
            y_acc_d = '0;
        end else if (step_i && !step_done_o) begin
            y_acc_d = y_acc_q + ACC_WIDTH'(y_scale_i);
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_acc_q <= '0;
        end else begin
            y_acc_q <= y_acc_d;
        end
    end
`else
    // Without line skipping every input line is kept and STEP never dwells.
    logic unused_sel;
    assign unused_sel  = ^{clk, rst_n, clear_i, step_i, y_scale_i, line_i};
    assign needed_o    = 1'b1;
    assign step_done_o = 1'b1;
`endif

endmodule

// File: rtl/scaler_line_writer.sv
// rtl/scaler_line_writer.sv - line-buffer FIFO feeder for the vertical scaler; LINE_SKIP_EN enables line skipping
module scaler_line_writer
    import scaler_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int ADDRESS_WIDTH     = 11,
    parameter int BUFFER_SIZE       = 4,
    parameter int BUFFER_SIZE_WIDTH = 3,
    parameter int INPUT_Y_RES_WIDTH = 11,
    parameter int SCALE_INT_BITS    = YS_INT_BITS,
    parameter int SCALE_FRAC_BITS   = YS_FRAC_BITS
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [ADDRESS_WIDTH-1:0]                  inputXRes,
    input  logic [INPUT_Y_RES_WIDTH-1:0]              inputYRes,
    input  logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0] yScale,
    input  logic [DATA_WIDTH-1:0]                     dIn,
    input  logic                                      dInValid,
    output logic                                      nextDin,
    input  logic [BUFFER_SIZE_WIDTH-1:0]              fillCount,
    output logic [DATA_WIDTH-1:0]                     writeData,
    output logic [ADDRESS_WIDTH-1:0]                  writeAddress,
    output logic                                      writeEnable,
    output logic                                      advanceWrite,
    output logic                                      frameDone
);

    localparam int SCALE_WIDTH = SCALE_INT_BITS + SCALE_FRAC_BITS;
    localparam logic [BUFFER_SIZE_WIDTH-1:0] FILL_LIMIT =
        BUFFER_SIZE_WIDTH'(BUFFER_SIZE - FIFO_GUARD);

    state_e                         state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]       col_q, col_d;
    logic [INPUT_Y_RES_WIDTH-1:0]   line_q, line_d;
    logic [ADDRESS_WIDTH-1:0]       x_res_q, x_res_d;
    logic [INPUT_Y_RES_WIDTH-1:0]   y_res_q, y_res_d;
    logic [DATA_WIDTH-1:0]          wr_data_q, wr_data_d;
    logic [ADDRESS_WIDTH-1:0]       wr_addr_q, wr_addr_d;
    logic                           wr_en_q, wr_en_d;
    logic                           adv_q, adv_d;
    logic                           done_q, done_d;

    logic                           next_din;
    logic                           sel_clear;
    logic                           sel_step;
    logic                           sel_needed;
    logic                           sel_step_done;
    logic [SCALE_WIDTH-1:0]         y_scale_sel;

`ifdef LINE_SKIP_EN
    logic [SCALE_WIDTH-1:0] y_scale_q;

    // Scale factor is captured together with the rest of the frame config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_scale_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            y_scale_q <= yScale;
        end
    end

    assign y_scale_sel = y_scale_q;
`else
    logic unused_y_scale;
    assign unused_y_scale = ^yScale;
    assign y_scale_sel    = '0;
`endif

    scaler_line_select #(
        .LINE_WIDTH      (INPUT_Y_RES_WIDTH),
        .SCALE_INT_BITS  (SCALE_INT_BITS),
        .SCALE_FRAC_BITS (SCALE_FRAC_BITS)
    ) u_line_select (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (sel_clear),
        .step_i      (sel_step),
        .y_scale_i   (y_scale_sel),
        .line_i      (line_q),
        .needed_o    (sel_needed),
        .step_done_o (sel_step_done)
    );

    // Next-state and output decode; write strobes are single-cycle by default
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        line_d    = line_q;
        x_res_d   = x_res_q;
        y_res_d   = y_res_q;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        wr_en_d   = 1'b0;
        adv_d     = 1'b0;
        done_d    = 1'b0;
        next_din  = 1'b0;
        sel_clear = 1'b0;
        sel_step  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_res_d   = inputXRes;
                    y_res_d   = inputYRes;
                    col_d     = '0;
                    line_d    = '0;
                    sel_clear = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Space for a whole line is reserved here so LINE never stalls
                if (!sel_needed) begin
                    state_d = ST_SKIP;
                end else if (fillCount < FILL_LIMIT) begin
                    state_d = ST_LINE;
                end
            end
            ST_LINE: begin
                next_din = 1'b1;
                if (dInValid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = col_q;
                    wr_data_d = dIn;
                    col_d     = col_q + 1'b1;
                    if (col_q == x_res_q) begin
                        state_d = ST_ADV;
                    end
                end
            end
            ST_SKIP: begin
                next_din = 1'b1;
                if (dInValid) begin
                    col_d = col_q + 1'b1;
                    if (col_q == x_res_q) begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_ADV: begin
                // Registered, so the pulse lands one cycle after the last write
                adv_d   = 1'b1;
                state_d = ST_STEP;
            end
            ST_STEP: begin
                if (!sel_step_done) begin
                    sel_step = 1'b1;
                end else begin
                    col_d  = '0;
                    line_d = line_q + 1'b1;
                    if (line_q == y_res_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns everything to idle/zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            line_q    <= '0;
            x_res_q   <= '0;
            y_res_q   <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= 1'b0;
            adv_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            line_q    <= line_d;
            x_res_q   <= x_res_d;
            y_res_q   <= y_res_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
            adv_q     <= adv_d;
            done_q    <= done_d;
        end
    end

    assign nextDin      = next_din;
    assign writeData    = wr_data_q;
    assign writeAddress = wr_addr_q;
    assign writeEnable  = wr_en_q;
    assign advanceWrite = adv_q;
    assign frameDone    = done_q;

endmodule

// File: tb/tb_scaler_line_writer.sv
// tb/tb_scaler_line_writer.sv - directed self-checking bench for scaler_line_writer
module tb_scaler_line_writer;

`ifdef LINE_SKIP_EN
    localparam logic [7:0] MASK_3X = 8'hDB;
    localparam int         GAP_QTR = 7;
`else
    localparam logic [7:0] MASK_3X = 8'hFF;
    localparam int         GAP_QTR = 3;
`endif
    localparam logic [7:0]  MASK_ALL = 8'hFF;
    localparam logic [17:0] YS_3X    = 18'h0C000;
    localparam logic [17:0] YS_1X    = 18'h04000;
    localparam logic [17:0] YS_QTR   = 18'h01000;

    localparam int M_NORM  = 0;
    localparam int M_RAND  = 1;
    localparam int M_STALL = 2;
    localparam int M_ABORT = 3;
    localparam int M_START = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] inputXRes = '0;
    logic [10:0] inputYRes = '0;
    logic [17:0] yScale = '0;
    logic [15:0] dIn = '0;
    logic        dInValid = 1'b0;
    logic        nextDin;
    logic [2:0]  fillCount = '0;
    logic [15:0] writeData;
    logic [10:0] writeAddress;
    logic        writeEnable;
    logic        advanceWrite;
    logic        frameDone;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    scaler_line_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .inputXRes    (inputXRes),
        .inputYRes    (inputYRes),
        .yScale       (yScale),
        .dIn          (dIn),
        .dInValid     (dInValid),
        .nextDin      (nextDin),
        .fillCount    (fillCount),
        .writeData    (writeData),
        .writeAddress (writeAddress),
        .writeEnable  (writeEnable),
        .advanceWrite (advanceWrite),
        .frameDone    (frameDone)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nth_line(input logic [7:0] m, input int n);
        int k;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (k == n) return i;
                k++;
            end
        end
        return 255;
    endfunction

    // Output monitor: expected line/column for each write comes from the line mask
    logic [7:0] exp_mask = '0;
    bit         mon_clr = 1'b0;
    int we_cnt = 0, adv_cnt = 0, fd_cnt = 0, bad_wr = 0, adv_bad = 0;
    int line_col = 0, gap = 0, max_gap = 0;
    bit prev_we = 1'b0, seen_din = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            we_cnt <= 0; adv_cnt <= 0; fd_cnt <= 0; bad_wr <= 0; adv_bad <= 0;
            line_col <= 0; gap <= 0; max_gap <= 0; prev_we <= 1'b0; seen_din <= 1'b0;
        end else begin
            if (writeEnable) begin
                if (writeAddress != 11'(line_col) ||
                    writeData != {8'(nth_line(exp_mask, adv_cnt)), 8'(line_col)})
                    bad_wr <= bad_wr + 1;
                we_cnt   <= we_cnt + 1;
                line_col <= line_col + 1;
            end
            if (advanceWrite) begin
                if (!prev_we || writeEnable || line_col != 8)
                    adv_bad <= adv_bad + 1;
                adv_cnt  <= adv_cnt + 1;
                line_col <= 0;
            end
            if (frameDone) fd_cnt <= fd_cnt + 1;
            if (nextDin) begin
                if (seen_din && gap > max_gap) max_gap <= gap;
                seen_din <= 1'b1;
                gap      <= 0;
            end else begin
                gap <= gap + 1;
            end
            prev_we <= writeEnable;
        end
    end

    task automatic run_frame(input string name, input logic [17:0] ys,
                             input logic [7:0] mask, input int mode);
        int sl, sc, sent, budget, nd_bad, w0;
        bit xfer, stalled, started, aborted;
        sl = 0; sc = 0; sent = 0; budget = 0;
        stalled = 1'b0; started = 1'b0; aborted = 1'b0;
        exp_mask = mask;
        @(posedge clk); mon_clr = 1'b1;
        @(posedge clk); mon_clr = 1'b0;
        @(negedge clk);
        inputXRes = 11'd7; inputYRes = 11'd7; yScale = ys; fillCount = '0; start = 1'b1;
        @(negedge clk);
        while (sent < 64 && budget < 4000) begin
            start = 1'b0; inputXRes = 11'd7; inputYRes = 11'd7; yScale = ys;
            if (mode == M_STALL && !stalled && sl == 2 && sc == 0) begin
                stalled = 1'b1;
                fillCount = 3'd3;
                #1 w0 = we_cnt;
                nd_bad = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (nextDin) nd_bad++;
                end
                check({name, "_stall_nextdin"}, nd_bad, 0);
                check({name, "_stall_writes"}, we_cnt, w0);
                fillCount = 3'd2;
                @(negedge clk);
                check({name, "_stall_release"}, nextDin, 1);
            end
            if (mode == M_START && !started && sl == 3 && sc == 2) begin
                started = 1'b1;
                start = 1'b1; inputXRes = 11'd3; inputYRes = 11'd1; yScale = '0;
            end
            if (mode == M_ABORT && sl == 1 && sc == 4) begin
                #2 rst_n = 1'b0;
                #1 check({name, "_reset_outputs"},
                         {writeEnable, advanceWrite, frameDone, nextDin, writeAddress, writeData}, 0);
                repeat (3) @(negedge clk);
                #2;
                check({name, "_reset_writes"}, we_cnt, 12);
                check({name, "_reset_no_adv"}, adv_cnt, 1);
                check({name, "_reset_no_done"}, fd_cnt, 0);
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            dInValid = (mode == M_RAND) ? 1'($urandom_range(0, 1)) : 1'b1;
            dIn = {8'(sl), 8'(sc)};
            xfer = dInValid && nextDin;
            @(posedge clk);
            if (xfer) begin
                sent++;
                if (sc == 7) begin sc = 0; sl++; end
                else sc++;
            end
            @(negedge clk);
            budget++;
        end
        dInValid = 1'b0;
        start = 1'b0;
        if (!aborted) begin
            check({name, "_xfers"}, sent, 64);
            for (int i = 0; i < 100 && fd_cnt == 0; i++) @(negedge clk);
            repeat (3) @(negedge clk);
            #1;
            check({name, "_frame_done"}, fd_cnt, 1);
            check({name, "_writes"}, we_cnt, 8 * $countones(mask));
            check({name, "_advances"}, adv_cnt, $countones(mask));
            check({name, "_bad_wr"}, bad_wr, 0);
            check({name, "_adv_timing"}, adv_bad, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {writeEnable, advanceWrite, frameDone, nextDin, writeAddress, writeData}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("scale3", YS_3X, MASK_3X, M_NORM);
        run_frame("scale1", YS_1X, MASK_ALL, M_NORM);
        run_frame("scale_qtr", YS_QTR, MASK_ALL, M_NORM);
        check("scale_qtr_gap", max_gap, GAP_QTR);
        run_frame("stall", YS_1X, MASK_ALL, M_STALL);
        run_frame("rand_valid", YS_3X, MASK_3X, M_RAND);
        run_frame("abort", YS_3X, MASK_3X, M_ABORT);
        run_frame("after_abort", YS_3X, MASK_3X, M_NORM);
        run_frame("start_ignored", YS_3X, MASK_3X, M_START);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scaler_line_writer.md
Name: scaler_line_writer

Overview:
- Upstream feeder of the scaler's line-buffer FIFO. Accepts the raw input pixel stream and decides which input lines the vertical bilinear stage needs; skips the rest.
- For each needed line it generates writeData/writeAddress/writeEnable, then a one-cycle advanceWrite pulse.
- Throttles the source using the FIFO's fillCount so a buffer being read is never overwritten.

Parameters:
- DATA_WIDTH, 16, pixel width
- ADDRESS_WIDTH, 11, line-RAM address width; max line length 2**ADDRESS_WIDTH
- BUFFER_SIZE, 4, number of line buffers in the FIFO
- BUFFER_SIZE_WIDTH, 3, width of fillCount
- INPUT_Y_RES_WIDTH, 11, width of line counter
- SCALE_INT_BITS, 4, integer bits of yScale
- SCALE_FRAC_BITS, 14, fraction bits of yScale

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  frame-start pulse, honoured only in IDLE
- inputXRes  in  ADDRESS_WIDTH  input width minus 1; sampled at start
- inputYRes  in  INPUT_Y_RES_WIDTH  input height minus 1; sampled at start
- yScale  in  SCALE_INT_BITS+SCALE_FRAC_BITS  input lines per output line, unsigned fixed point; sampled at start
- dIn  in  DATA_WIDTH  input pixel
- dInValid  in  1  pixel valid
- nextDin  out  1  ready; a pixel transfers when dInValid && nextDin
- fillCount  in  BUFFER_SIZE_WIDTH  completed lines held in the FIFO
- writeData  out  DATA_WIDTH  registered pixel
- writeAddress  out  ADDRESS_WIDTH  column index
- writeEnable  out  1  write strobe
- advanceWrite  out  1  one-cycle pulse, register output, glitch-free
- frameDone  out  1  one-cycle pulse after the last input line

Behaviour:
- Reset: state IDLE. All outputs 0. col, line and yAcc are 0.
- FSM states: IDLE, WAIT, LINE, SKIP, ADV, STEP, DONE.
- IDLE: on start, latch configuration, clear yAcc/line/col, go to WAIT.
- yNeed is the integer part of yAcc; yAcc is INPUT_Y_RES_WIDTH+SCALE_FRAC_BITS bits wide.
  - Line L is needed iff yNeed == L-1 or yNeed == L.
  - Otherwise (yNeed > L) it is skipped.
- WAIT: if line L is not needed, go to SKIP. If needed and fillCount < BUFFER_SIZE-1, go to LINE. Otherwise hold with nextDin = 0.
- LINE:
  - nextDin = 1.
  - Each transfer: on the next cycle writeEnable = 1, writeAddress = col, writeData = dIn. Latency is 1 clk.
  - col then increments.
  - The transfer at col == inputXRes ends the line and moves to ADV.
  - No stall occurs mid-line; buffer space was reserved in WAIT.
- SKIP: nextDin = 1; pixels are consumed without writes. The transfer at col == inputXRes goes to STEP.
- ADV: advanceWrite = 1 for exactly one cycle, in the cycle after the last writeEnable. Then go to STEP.
- STEP:
  - If yScale != 0 and yNeed < L, do yAcc += yScale and stay in STEP (one add per cycle).
  - Otherwise clear col and increment L.
  - If the old L == inputYRes, go to DONE; else go to WAIT.
- yScale == 0 never loops: every line is written.
- DONE: frameDone = 1 for one cycle, then IDLE.
- Configuration inputs are ignored outside IDLE.
- start in a non-IDLE state is ignored.
- fillCount is sampled only in WAIT. The post-ADV STEP cycle guarantees the FIFO has updated before it is sampled.
- rst_n asserted mid-line: immediate return to reset values. advanceWrite must not pulse as a side effect.
- yAcc overflow is not possible for legal configurations.

Optional Feature:
- Macro: LINE_SKIP_EN.
- Defined: line selection as above.
- Undefined:
  - Every input line is needed; SKIP is unreachable.
  - STEP performs no additions.
  - yScale is ignored and the accumulator logic is removed.

Decomposition:
- Shared package scaler_pkg: FSM state enum; constants FIFO_GUARD = 1 (free-buffer margin); yScale fixed-point widths.
- Natural sub-module: scaler_line_select. It holds yAcc/yNeed, takes L, and produces needed/stepDone.

Test Plan:
- inputXRes=7, inputYRes=7, yScale=0xC000 (3.0), fillCount held 0 → lines 0,1,3,4,6,7 written; 6 advanceWrite pulses; 48 writeEnables; addresses 0..7 per line; frameDone once.
- Same frame, yScale=0x4000 (1.0) → 8 lines written, 8 pulses. yScale=0x1000 (0.25) → 8 lines written, STEP dwell ≤ 4 cycles per line.
- fillCount forced to 3 (BUFFER_SIZE-1) before line 2 → nextDin = 0 and no writes. Drop to 2 → LINE entered on the next cycle.
- dInValid toggled randomly → write data and addresses identical to the unstalled run; advanceWrite exactly 1 cycle after the final write.
- rst_n pulsed low at col 4 of line 1 → all outputs 0 immediately; no advanceWrite; a new start produces a correct frame.
- start asserted during LINE → ignored. Build without LINE_SKIP_EN and yScale=3.0 → all 8 lines written.
